// File: rtl/spi_ram_burst_slave_if.sv
// Serial link between an SPI master and spi_ram_burst_slave.
// The master drives the frame select and serial data in; the slave returns registered read data.
interface spi_ram_burst_slave_if;
    logic MOSI;
    logic SS_n;
    logic MISO;

    modport master (output MOSI, output SS_n, input MISO);
    modport slave  (input MOSI, input SS_n, output MISO);
endinterface

// File: rtl/spi_ram_burst_slave.sv
// SPI slave with an embedded single-port RAM, clocked by the system clock.
// Define SPI_AUTOINC_EN to stream consecutive words per WR_DATA/RD_DATA frame.
module spi_ram_burst_slave #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_ram_burst_slave_if.slave  spi
);

    localparam int SW = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0]   DEPTH_W   = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]        ADDR_LAST = CW'(ADDR_SIZE - 1);
    localparam logic [CW-1:0]        DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_DATA, HOLD
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [SW-1:0]           shift_q;
    logic                    op_q;
    logic [ADDR_SIZE-1:0]    wrAddr_q;
    logic [ADDR_SIZE-1:0]    rdAddr_q;
    logic [ADDR_SIZE-1:0]    wAddrPend_q;
    logic [DATA_WIDTH-1:0]   wBuf_q;
    logic                    wPend_q;
    logic [DATA_WIDTH-1:0]   rdWord_q;
    logic                    miso_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [SW-1:0]           shiftIn_d;
    logic [DATA_WIDTH-1:0]   rdData_d;

    function automatic logic inRange(input logic [ADDR_SIZE-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    assign shiftIn_d = {shift_q[SW-2:0], spi.MOSI};
    assign rdData_d  = inRange(rdAddr_q) ? mem[rdAddr_q[IW-1:0]] : '0;
    assign spi.MISO  = miso_q;

`ifdef SPI_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0]    wrAddrInc_d;
    logic [ADDR_SIZE-1:0]    rdAddrInc_d;
    logic [DATA_WIDTH-1:0]   nextData_d;

    // The last in-range address wraps to zero; anything beyond simply counts up.
    assign wrAddrInc_d = (wrAddr_q == LAST_ADDR) ? '0 : wrAddr_q + ADDR_ONE;
    assign rdAddrInc_d = (rdAddr_q == LAST_ADDR) ? '0 : rdAddr_q + ADDR_ONE;
    assign nextData_d  = inRange(rdAddrInc_d) ? mem[rdAddrInc_d[IW-1:0]] : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            op_q        <= 1'b0;
            wrAddr_q    <= '0;
            rdAddr_q    <= '0;
            wAddrPend_q <= '0;
            wBuf_q      <= '0;
            wPend_q     <= 1'b0;
            rdWord_q    <= '0;
            miso_q      <= 1'b0;
        end else begin
            wPend_q <= 1'b0;
            miso_q  <= 1'b0;
            if (spi.SS_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= CMD;
                        cnt_q   <= '0;
                    end
                    CMD: begin
                        op_q  <= spi.MOSI;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            cnt_q <= '0;
                            case ({op_q, spi.MOSI})
                                2'b00:   state_q <= WR_ADDR;
                                2'b01:   state_q <= WR_DATA;
                                2'b10:   state_q <= RD_ADDR;
                                default: state_q <= RD_WAIT;
                            endcase
                        end
                    end
                    WR_ADDR: begin
                        shift_q <= shiftIn_d;
                        cnt_q   <= cnt_q + CNT_ONE;
                        if (cnt_q == ADDR_LAST) begin
                            wrAddr_q <= shiftIn_d[ADDR_SIZE-1:0];
                            cnt_q    <= '0;
                            state_q  <= HOLD;
                        end
                    end
                    RD_ADDR: begin
                        shift_q <= shiftIn_d;
                        cnt_q   <= cnt_q + CNT_ONE;
                        if (cnt_q == ADDR_LAST) begin
                            rdAddr_q <= shiftIn_d[ADDR_SIZE-1:0];
                            cnt_q    <= '0;
                            state_q  <= HOLD;
                        end
                    end
                    WR_DATA: begin
                        shift_q <= shiftIn_d;
                        cnt_q   <= cnt_q + CNT_ONE;
                        // A complete word is committed to RAM on the following edge.
                        if (cnt_q == DATA_LAST) begin
                            wBuf_q      <= shiftIn_d[DATA_WIDTH-1:0];
                            wAddrPend_q <= wrAddr_q;
                            wPend_q     <= 1'b1;
                            cnt_q       <= '0;
`ifdef SPI_AUTOINC_EN
                            wrAddr_q    <= wrAddrInc_d;
`else
                            state_q     <= HOLD;
`endif
                        end
                    end
                    RD_WAIT: begin
                        rdWord_q <= rdData_d;
                        cnt_q    <= '0;
                        state_q  <= RD_DATA;
                    end
                    RD_DATA: begin
                        miso_q   <= rdWord_q[DATA_WIDTH-1];
                        rdWord_q <= rdWord_q << 1;
                        cnt_q    <= cnt_q + CNT_ONE;
                        if (cnt_q == DATA_LAST) begin
                            cnt_q    <= '0;
`ifdef SPI_AUTOINC_EN
                            rdWord_q <= nextData_d;
                            rdAddr_q <= rdAddrInc_d;
`else
                            state_q  <= HOLD;
`endif
                        end
                    end
                    HOLD:    state_q <= HOLD;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // RAM is deliberately left out of reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wPend_q && inRange(wAddrPend_q)) begin
            mem[wAddrPend_q[IW-1:0]] <= wBuf_q;
        end
    end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Bench driving two slaves (depth 256 and 200) with identical frames and
// checking MISO every cycle against a word-level model of RAM and address registers.
module tb_spi_ram_burst_slave;

    localparam int DW = 8;
`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       exp256q[$];
    logic       exp200q[$];
    int         depth[2] = '{256, 200};
    logic [7:0] mem[2][256];
    int         wrA[2];
    int         rdA[2];
    logic       lastMiso[2];

    spi_ram_burst_slave_if spi256 ();
    spi_ram_burst_slave_if spi200 ();

    spi_ram_burst_slave #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8)) dut256 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi256)
    );

    spi_ram_burst_slave #(.MEM_DEPTH(200), .ADDR_SIZE(8), .DATA_WIDTH(8)) dut200 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi200)
    );

    always #5 clk = ~clk;

    function automatic int incA(input int d, input int a);
        return (a == depth[d] - 1) ? 0 : (a + 1) % 256;
    endfunction

    function automatic logic [7:0] rdM(input int d, input int a);
        return (a < depth[d]) ? mem[d][a] : 8'h00;
    endfunction

    // Every edge the bench drives carries the MISO value required after it.
    always @(negedge clk) begin
        logic e;
        if (exp256q.size() > 0) begin
            e = exp256q.pop_front();
            checks++;
            if (spi256.MISO !== e) begin
                errors++;
                $display("[TB] FAIL miso256 at %0t got %b expected %b", $time, spi256.MISO, e);
            end
        end
        if (exp200q.size() > 0) begin
            e = exp200q.pop_front();
            checks++;
            if (spi200.MISO !== e) begin
                errors++;
                $display("[TB] FAIL miso200 at %0t got %b expected %b", $time, spi200.MISO, e);
            end
        end
    end

    task automatic applyStimulus(input logic rn, input logic ss, input logic mosi,
                                 input logic e0, input logic e1);
        @(negedge clk);
        rst_n       = rn;
        spi256.SS_n = ss;
        spi256.MOSI = mosi;
        spi200.SS_n = ss;
        spi200.MOSI = mosi;
        @(posedge clk);
        exp256q.push_back(e0);
        exp200q.push_back(e1);
        #1;
        lastMiso[0] = spi256.MISO;
        lastMiso[1] = spi200.MISO;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic t;
            t = i[0];
            applyStimulus(1'b0, 1'b1, t, 1'b0, 1'b0);
        end
        for (int d = 0; d < 2; d++) begin
            wrA[d] = 0;
            rdA[d] = 0;
        end
    endtask

    // One frame: start edge, two opcode edges, nPay payload edges, then SS_n high.
    task automatic runFrame(input logic [1:0] op, input int nPay, input logic [31:0] payload,
                            output logic [31:0] got0, output logic [31:0] got1);
        logic       e[2];
        logic       m;
        logic [7:0] w;
        int         words;
        int         a;
        got0 = '0;
        got1 = '0;
        for (int i = 0; i < 3 + nPay; i++) begin
            if (i == 1)                     m = op[1];
            else if (i == 2)                m = op[0];
            else if (i >= 3 && op != 2'b11) m = payload[nPay - 1 - (i - 3)];
            else                            m = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e[d] = 1'b0;
                if (op == 2'b11 && i >= 4) begin
                    int j;
                    int wi;
                    j  = i - 4;
                    wi = j / DW;
                    if (AUTOINC || wi == 0) begin
                        a = rdA[d];
                        for (int k = 0; k < wi; k++) a = incA(d, a);
                        w    = rdM(d, a);
                        e[d] = w[DW - 1 - (j % DW)];
                    end
                end
            end
            applyStimulus(1'b1, 1'b0, m, e[0], e[1]);
            if (op == 2'b11 && i >= 4) begin
                got0 = {got0[30:0], lastMiso[0]};
                got1 = {got1[30:0], lastMiso[1]};
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        words = (op == 2'b11) ? (nPay - 1) / DW : nPay / DW;
        for (int d = 0; d < 2; d++) begin
            case (op)
                2'b00: if (words >= 1) wrA[d] = int'(payload[nPay - 1 -: 8]);
                2'b10: if (words >= 1) rdA[d] = int'(payload[nPay - 1 -: 8]);
                2'b01: begin
                    for (int k = 0; k < words && (AUTOINC || k == 0); k++) begin
                        w = payload[nPay - 1 - 8 * k -: 8];
                        if (wrA[d] < depth[d]) mem[d][wrA[d]] = w;
                        if (AUTOINC) wrA[d] = incA(d, wrA[d]);
                    end
                end
                default: begin
                    if (AUTOINC) begin
                        for (int k = 0; k < words; k++) rdA[d] = incA(d, rdA[d]);
                    end
                end
            endcase
        end
    endtask

    task automatic writeWord(input logic [7:0] addr, input logic [7:0] data);
        logic [31:0] g0, g1;
        runFrame(2'b00, 8, {24'h0, addr}, g0, g1);
        runFrame(2'b01, 9, {23'h0, data, 1'b0}, g0, g1);
    endtask

    task automatic readWords(input logic [7:0] addr, input int nBits,
                             output logic [31:0] g0, output logic [31:0] g1);
        runFrame(2'b10, 8, {24'h0, addr}, g0, g1);
        runFrame(2'b11, nBits + 1, 32'h0, g0, g1);
    endtask

    initial begin
        logic [31:0] g0, g1;
        spi256.SS_n = 1'b1;
        spi256.MOSI = 1'b0;
        spi200.SS_n = 1'b1;
        spi200.MOSI = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) mem[d][a] = 8'h00;
        end

        resetCycles(4);
        writeWord(8'h00, 8'h3C);
        writeWord(8'hC7, 8'h5E);
        writeWord(8'h20, 8'h81);
        writeWord(8'hFF, 8'h99);
        writeWord(8'h01, 8'h0F);
        writeWord(8'hFE, 8'hEE);

        // RAM must survive a reset taken with MOSI toggling.
        resetCycles(5);
        readWords(8'h00, 8, g0, g1);
        checkOutput("reset_keeps_ram256", g0, 32'h3C);
        checkOutput("reset_keeps_ram200", g1, 32'h3C);

        writeWord(8'h10, 8'hA5);
        readWords(8'h10, 8, g0, g1);
        checkOutput("rd_a5_256", g0, 32'hA5);
        checkOutput("rd_a5_200", g1, 32'hA5);

        runFrame(2'b00, 8, 32'hFE, g0, g1);
        runFrame(2'b01, 25, {7'h0, 24'h112233, 1'b0}, g0, g1);
        checkOutput("model_fe", mem[0][8'hFE], 32'h11);
        checkOutput("model_ff", mem[0][8'hFF], AUTOINC ? 32'h22 : 32'h99);
        checkOutput("model_00", mem[0][8'h00], AUTOINC ? 32'h33 : 32'h3C);
        checkOutput("model_wraddr", wrA[0], AUTOINC ? 32'h01 : 32'hFE);
        checkOutput("model200_00", mem[1][8'h00], AUTOINC ? 32'h33 : 32'h3C);

        runFrame(2'b01, 9, {23'h0, 8'h44, 1'b0}, g0, g1);
        readWords(8'h01, 8, g0, g1);
        checkOutput("wraddr_after_burst256", g0, AUTOINC ? 32'h44 : 32'h0F);
        checkOutput("wraddr_after_burst200", g1, AUTOINC ? 32'h44 : 32'h0F);

        readWords(8'hFF, 16, g0, g1);
        checkOutput("rd_burst_wrap256", g0, AUTOINC ? 32'h2233 : 32'h9900);
        checkOutput("rd_burst_wrap200", g1, AUTOINC ? 32'h0033 : 32'h0000);

        runFrame(2'b00, 8, 32'h20, g0, g1);
        runFrame(2'b01, 5, 32'h0B, g0, g1);
        readWords(8'h20, 8, g0, g1);
        checkOutput("abort_no_write256", g0, 32'h81);
        checkOutput("abort_no_write200", g1, 32'h81);
        runFrame(2'b00, 8, 32'h20, g0, g1);
        runFrame(2'b01, 9, {23'h0, 8'h5A, 1'b0}, g0, g1);
        readWords(8'h20, 8, g0, g1);
        checkOutput("after_abort256", g0, 32'h5A);
        checkOutput("after_abort200", g1, 32'h5A);

        writeWord(8'hC8, 8'h77);
        readWords(8'hC8, 8, g0, g1);
        checkOutput("range_c8_256", g0, 32'h77);
        checkOutput("range_c8_200", g1, 32'h00);
        readWords(8'hC7, 16, g0, g1);
        checkOutput("inc_from_c7_256", g0, AUTOINC ? 32'h5E77 : 32'h5E00);
        checkOutput("inc_from_c7_200", g1, AUTOINC ? 32'h5E33 : 32'h5E00);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI slave with an embedded single-port RAM: the next generation of the team's 8-bit SPI-to-RAM slave, generalised in address and data width and memory depth, adding burst (auto-increment) transfers and out-of-range address protection. It sits between an external SPI master (MOSI/SS_n/MISO) and on-chip storage, and runs entirely on the system clock, which samples the serial lines directly.

## Interface
- MEM_DEPTH, 256, number of RAM words; any value 2..2^ADDR_SIZE, need not be a power of two
- ADDR_SIZE, 8, address register and address-payload width in bits
- DATA_WIDTH, 8, RAM word and data-payload width in bits

- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- MOSI  input  1  serial data from master, sampled on clk rising edge
- SS_n  input  1  active-low frame select, sampled on clk rising edge
- MISO  output  1  serial read data to master, registered

## Operation
- Frame = SS_n sampled low on consecutive edges. Bit order MSB first throughout.
- Frame layout: 1 start cycle (MOSI ignored), 2 opcode bits, then payload.
- Opcodes: 00 WR_ADDR (ADDR_SIZE bits -> wr_addr), 01 WR_DATA (DATA_WIDTH bits -> RAM[wr_addr]), 10 RD_ADDR (ADDR_SIZE bits -> rd_addr), 11 RD_DATA (slave shifts RAM[rd_addr] out on MISO; MOSI ignored).
- wr_addr and rd_addr are independent registers; both persist across frames.
- FSM states: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_DATA, HOLD.
- IDLE -> CMD on first edge with SS_n low. CMD consumes 2 opcode bits, then -> payload state (RD_DATA path goes via RD_WAIT).
- After a complete payload word: with auto-increment (see Configuration) WR_DATA/RD_DATA continue with the next word; otherwise -> HOLD, ignoring MOSI until SS_n high. WR_ADDR/RD_ADDR always -> HOLD.
- Any edge with SS_n high: -> IDLE, partial shift discarded, no RAM write, MISO = 0.
- Address range: write to address >= MEM_DEPTH is dropped; read from address >= MEM_DEPTH returns 0.
- Auto-increment: address + 1; address MEM_DEPTH-1 wraps to 0.
- RAM contents are not reset.

## Timing
- Reset (rst_n low at edge): state IDLE, MISO 0, wr_addr 0, rd_addr 0, shift counters 0. Reset mid-frame aborts exactly like SS_n high.
- Edge s: SS_n first low, start cycle. Edges s+1, s+2: opcode bits. Payload bits at s+3 onward.
- Write: last data bit sampled at edge k; RAM updated at edge k+1; in burst, next word's MSB also sampled at k+1 (no gap).
- Read: opcode complete at edge e; e+1 RAM read (RD_WAIT); MISO carries bit DATA_WIDTH-1 after edge e+2, bit 0 after edge e+1+DATA_WIDTH; master samples each bit on the following edge.
- Read burst: next word prefetched during current word; next MSB driven after edge e+2+DATA_WIDTH, no gap.
- MISO = 0 in every state except RD_DATA.
- SS_n high and last data bit on the same edge: SS_n wins, word discarded.

## Configuration
- SPI_AUTOINC_EN defined: WR_DATA and RD_DATA frames stream consecutive words while SS_n stays low; the respective address increments (with wrap) after each complete word.
- Not defined: one word per frame, address unchanged by data transfers, extra bits ignored in HOLD.

## Test plan
- Reset with SS_n high, MOSI toggling -> MISO 0 on every cycle; subsequent read of address 0 returns power-on RAM value unaltered by reset.
- WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA (separate frames) -> MISO bits 1,0,1,0,0,1,0,1 starting edge e+2.
- SPI_AUTOINC_EN: WR_ADDR 0xFE then one WR_DATA frame 0x11,0x22,0x33 -> RAM[0xFE]=0x11, RAM[0xFF]=0x22, RAM[0x00]=0x33, wr_addr 0x01; without macro only RAM[0xFE]=0x11 changes.
- SPI_AUTOINC_EN: RD_ADDR 0xFF, RD_DATA for 16 bits -> MISO streams 0x22 then 0x33 with no idle cycle between words.
- WR_DATA 0x5A to address 0x20, SS_n raised after 5 data bits -> RAM[0x20] unchanged, MISO 0; next complete frame executes normally.
- MEM_DEPTH=200: write 0x77 to address 0xC8 -> no RAM change, read of 0xC8 returns 0x00; auto-increment from 199 goes to 0.
